// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

    // Parity selection encoding.
    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Receiver FSM state encoding.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } rx_state_e;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int unsigned osr_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud * 8) / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; drops new data when full unless a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             dropped
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             dropped_q;
    logic             empty, full, do_pop, do_push;

    // Handshake decode: a pop while full makes room for a same-cycle push
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FullCnt);
        do_pop  = pop_req && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointers and occupancy; pointers wrap modulo DEPTH as DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            dropped_q <= push && !do_push;
        end
    end

    // Storage is not reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Head presentation, zero when empty
    always_comb begin
        valid   = !empty;
        head    = empty ? '0 : mem_q[rd_ptr_q];
        dropped = dropped_q;
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: synchroniser, 16x oversampling framer with majority vote, and result FIFO.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PARITY_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [8:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned DivRaw = osr_div(CLK_HZ, BAUD);
    localparam int unsigned DIV    = (DivRaw == 0) ? 1 : DivRaw;
    localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam int unsigned FrameW = 11;

    rx_state_e state_q, state_d;

    logic [1:0]           sync_q;
    logic                 rx_s, rx_prev_q;
    logic [DivW-1:0]      div_cnt_q, div_cnt_d;
    logic [3:0]           os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 wait_high_q, wait_high_d;

    logic              tick, mid_tick, bit_end, vote, last_data, last_stop, start_edge;
    logic              push, parity_err, frame_ferr;
    logic [8:0]        data_ext;
    logic [FrameW-1:0] frame, head;

    assign rx_s = sync_q[1];

    // Two-flop synchroniser plus edge-history flop, all idle-high at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    // Tick, vote and bit-position decode
    always_comb begin
        tick       = (div_cnt_q == DivLast);
        mid_tick   = tick && (os_cnt_q == 4'd9);
        bit_end    = tick && (os_cnt_q == 4'd15);
        vote       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
        last_data  = (bit_cnt_q == 4'(DATA_BITS - 1));
        last_stop  = (bit_cnt_q == 4'(STOP_BITS - 1));
        start_edge = (state_q == StIdle) && !wait_high_q && rx_prev_q && !rx_s;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next-state; STOP returns to IDLE at the final stop-bit vote
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_edge) state_d = StStart;
            StStart: begin
                if (mid_tick && vote) state_d = StIdle;
                else if (bit_end)     state_d = StData;
            end
            StData: begin
                if (bit_end && last_data) begin
                    state_d = (PARITY == PARITY_NONE) ? StStop : StPar;
                end
            end
            StPar:   if (bit_end) state_d = StStop;
            StStop:  if (mid_tick && last_stop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and the frame word pushed at the final stop vote
    always_comb begin
        busy     = (state_q != StIdle);
        push     = (state_q == StStop) && mid_tick && last_stop;
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = shift_q;
        parity_err = 1'b0;
        if (PARITY != PARITY_NONE) begin
            parity_err = (^shift_q ^ par_q) != (PARITY == PARITY_ODD);
        end
        frame_ferr = ferr_q | ~vote;
        frame      = {parity_err, frame_ferr, data_ext};
    end

    // Datapath next-state: counters restart on an accepted start edge
    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        os_cnt_d    = tick ? os_cnt_q + 4'd1 : os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        vote_d      = vote_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ferr_d      = ferr_q;
        wait_high_d = wait_high_q;
        if (tick && os_cnt_q == 4'd7) vote_d[0] = rx_s;
        if (tick && os_cnt_q == 4'd8) vote_d[1] = rx_s;
        if (rx_s) wait_high_d = 1'b0;
        if (start_edge) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            ferr_d    = 1'b0;
        end
        if (mid_tick) begin
            case (state_q)
                StData:  shift_d = {vote, shift_q[DATA_BITS-1:1]};
                StPar:   par_d = vote;
                StStop:  if (!vote) ferr_d = 1'b1;
                default: ;
            endcase
        end
        if (bit_end) begin
            case (state_q)
                StData:  bit_cnt_d = last_data ? 4'd0 : bit_cnt_q + 4'd1;
                StStop:  bit_cnt_d = bit_cnt_q + 4'd1;
                default: ;
            endcase
        end
        // A broken frame (line possibly in break) must see idle before re-arming
        if (push && frame_ferr) wait_high_d = 1'b1;
    end

    // Datapath registers; wait_high resets set so a low line at release is not a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            vote_q      <= 2'b11;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            vote_q      <= vote_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (FrameW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (frame),
        .pop_req   (rx_ready),
        .head      (head),
        .valid     (rx_valid),
        .dropped   (overrun)
    );

    assign rx_perr = head[10];
    assign rx_ferr = head[9];
    assign rx_data = head[8:0];

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomised bench for uart_rx_framer: three configurations checked against a frame-level model.
module tb_uart_rx_framer;
    localparam int unsigned CLK_HZ    = 25_000_000;
    localparam int unsigned BAUD_DEF  = 115200;
    localparam int unsigned BAUD_FAST = 460800;
    localparam int unsigned FIFO_N    = 4;
    // Expected oversample divisors, rounded to nearest
    localparam int unsigned DIV_DEF   = (2 * CLK_HZ + 16 * BAUD_DEF) / (32 * BAUD_DEF);
    localparam int unsigned DIV_FAST  = (2 * CLK_HZ + 16 * BAUD_FAST) / (32 * BAUD_FAST);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lines;
    logic [2:0] ready;
    wire  [2:0] valid, perr, ferr, busy, ovr;
    wire  [8:0] data0, data1, data2;

    int tests_run = 0;
    int tests_failed = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    // Default configuration (8N1)
    uart_rx_framer ua (
        .clk (clk), .rst_n (rst_n), .uart_rx (lines[0]), .rx_data (data0),
        .rx_perr (perr[0]), .rx_ferr (ferr[0]), .rx_valid (valid[0]),
        .rx_ready (ready[0]), .overrun (ovr[0]), .busy (busy[0])
    );

    // Even parity
    uart_rx_framer #(.BAUD (BAUD_FAST), .PARITY (2)) up (
        .clk (clk), .rst_n (rst_n), .uart_rx (lines[1]), .rx_data (data1),
        .rx_perr (perr[1]), .rx_ferr (ferr[1]), .rx_valid (valid[1]),
        .rx_ready (ready[1]), .overrun (ovr[1]), .busy (busy[1])
    );

    // 7 data bits, 2 stop bits
    uart_rx_framer #(.BAUD (BAUD_FAST), .DATA_BITS (7), .STOP_BITS (2)) u7 (
        .clk (clk), .rst_n (rst_n), .uart_rx (lines[2]), .rx_data (data2),
        .rx_perr (perr[2]), .rx_ferr (ferr[2]), .rx_valid (valid[2]),
        .rx_ready (ready[2]), .overrun (ovr[2]), .busy (busy[2])
    );

    always @(negedge clk) if (ovr[0] === 1'b1) ovr_cnt++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int bit_clk(input int sel);
        return (sel == 0) ? 16 * DIV_DEF : 16 * DIV_FAST;
    endfunction

    function automatic logic [11:0] get_word(input int sel);
        case (sel)
            0:       return {valid[0], perr[0], ferr[0], data0};
            1:       return {valid[1], perr[1], ferr[1], data1};
            default: return {valid[2], perr[2], ferr[2], data2};
        endcase
    endfunction

    // Reference: {perr, ferr, data} derived from the frame's line contents
    function automatic logic [10:0] model_word(input int nbits, input int pmode,
                                               input logic [8:0] data, input logic par_bit,
                                               input int nstop, input logic [1:0] stop_lv);
        logic [9:0] mask;
        logic [8:0] d;
        int         ones;
        logic       pe, fe;
        mask = (10'h1 << nbits) - 10'h1;
        d    = data & mask[8:0];
        ones = $countones(d) + int'(par_bit);
        if (pmode == 0)      pe = 1'b0;
        else if (pmode == 1) pe = (ones % 2 == 0);
        else                 pe = (ones % 2 == 1);
        fe = (stop_lv[0] == 1'b0) || (nstop == 2 && stop_lv[1] == 1'b0);
        return {pe, fe, d};
    endfunction

    task automatic drive_bit(input int sel, input logic v);
        lines[sel] = v;
        repeat (bit_clk(sel)) @(negedge clk);
    endtask

    task automatic idle_bits(input int sel, input int n);
        lines[sel] = 1'b1;
        repeat (n * bit_clk(sel)) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit par_en, input logic par_bit, input int nstop,
                              input logic [1:0] stop_lv);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        if (par_en) drive_bit(sel, par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stop_lv[i]);
    endtask

    // Wait (bounded) for a head frame, compare it, then pop it
    task automatic pop_check(input int sel, input logic [10:0] exp, input string name);
        int waited = 0;
        while (valid[sel] !== 1'b1 && waited < 4 * bit_clk(sel)) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (get_word(sel) !== {1'b1, exp}) begin
            tests_failed++;
            $display("FAIL %s: got {valid,perr,ferr,data}=%h required %h", name,
                     get_word(sel), {1'b1, exp});
        end
        ready[sel] = 1'b1;
        @(negedge clk);
        ready[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        lines = 3'b111;
        ready = 3'b000;
        repeat (5) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if ({get_word(s), busy[s], ovr[s]} !== 14'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got %h required 0", s,
                         {get_word(s), busy[s], ovr[s]});
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        ready[0] = 1'b0;
        tests_run++;
        if ({get_word(0), busy[0]} !== 13'h0) begin
            tests_failed++;
            $display("FAIL empty_ready_ignored: got %h required 0", {get_word(0), busy[0]});
        end
    endtask

    task automatic test_basic_a5;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
        pop_check(0, model_word(8, 0, 9'h0A5, 1'b0, 1, 2'b11), "frame_8n1_a5");
        idle_bits(0, 1);
    endtask

    task automatic test_random_8n1;
        for (int i = 0; i < 4; i++) begin
            logic [8:0] d;
            logic [1:0] st;
            d  = 9'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            send_frame(0, d, 8, 1'b0, 1'b0, 1, st);
            pop_check(0, model_word(8, 0, d, 1'b0, 1, st), "random_8n1");
            idle_bits(0, 1);
        end
    endtask

    task automatic test_framing;
        int busy_cycles = 0;
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 2'b00);
        pop_check(0, model_word(8, 0, 9'h055, 1'b0, 1, 2'b00), "ferr_0x55");
        // Line held in break: nothing may start
        repeat (2 * bit_clk(0)) begin
            @(negedge clk);
            if (busy[0] === 1'b1) busy_cycles++;
        end
        tests_run++;
        if (busy_cycles != 0 || valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_no_start: got busy_cycles=%0d valid=%b required 0,0",
                     busy_cycles, valid[0]);
        end
        idle_bits(0, 1);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b11);
        pop_check(0, model_word(8, 0, 9'h05A, 1'b0, 1, 2'b11), "after_break_0x5a");
        idle_bits(0, 1);
    endtask

    task automatic test_glitch;
        bit saw_busy = 1'b0;
        int waited = 0;
        lines[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy[0] === 1'b1) saw_busy = 1'b1;
        end
        lines[0] = 1'b1;
        while (busy[0] !== 1'b0 && waited < bit_clk(0)) begin
            if (busy[0] === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (saw_busy !== 1'b1 || busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: got saw_busy=%b busy=%b required 1,0", saw_busy, busy[0]);
        end
        idle_bits(0, 11);
        tests_run++;
        if (valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_no_push: got valid=%b required 0", valid[0]);
        end
    endtask

    task automatic test_overrun;
        logic [10:0] q[$];
        int drops = 0;
        int base;
        base = ovr_cnt;
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 9'(v), 8, 1'b0, 1'b0, 1, 2'b11);
            if (q.size() < FIFO_N) q.push_back(model_word(8, 0, 9'(v), 1'b0, 1, 2'b11));
            else drops++;
            idle_bits(0, 1);
            tests_run++;
            if (ovr_cnt - base != drops) begin
                tests_failed++;
                $display("FAIL overrun_count frame %0d: got %0d required %0d", v,
                         ovr_cnt - base, drops);
            end
        end
        while (q.size() > 0) pop_check(0, q.pop_front(), "overrun_pop");
        tests_run++;
        if (valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_drained: got valid=%b required 0", valid[0]);
        end
    endtask

    task automatic test_parity_even;
        send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 2'b11);
        pop_check(1, model_word(8, 2, 9'h03C, 1'b1, 1, 2'b11), "even_parity_0x3c");
        idle_bits(1, 1);
        for (int i = 0; i < 4; i++) begin
            logic [8:0] d;
            logic       p;
            d = 9'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            send_frame(1, d, 8, 1'b1, p, 1, 2'b11);
            pop_check(1, model_word(8, 2, d, p, 1, 2'b11), "random_even_parity");
            idle_bits(1, 1);
        end
    endtask

    task automatic test_7n2;
        send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b11);
        pop_check(2, model_word(7, 0, 9'h07F, 1'b0, 2, 2'b11), "frame_7n2_7f");
        idle_bits(2, 1);
        for (int i = 0; i < 3; i++) begin
            logic [8:0] d;
            logic [1:0] st;
            d  = 9'($urandom_range(0, 511));
            st = 2'($urandom_range(0, 3));
            send_frame(2, d, 7, 1'b0, 1'b0, 2, st);
            pop_check(2, model_word(7, 0, d, 1'b0, 2, st), "random_7n2");
            idle_bits(2, 2);
        end
    endtask

    task automatic test_reset_mid_frame;
        drive_bit(2, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(2, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy_clear: got busy=%b required 0", busy[2]);
        end
        rst_n = 1'b1;
        for (int i = 3; i < 7; i++) drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        idle_bits(2, 2);
        tests_run++;
        if (valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_frame_no_push: got valid=%b busy=%b required 0,0",
                     valid[2], busy[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_random_8n1();
        test_framing();
        test_glitch();
        test_overrun();
        test_parity_even();
        test_7n2();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, range 5..9, data bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, with 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, range 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, range 2..16.
REQ-007 SHALL have port clk, input, 1 bit, system clock.
REQ-008 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-009 SHALL have port uart_rx, input, 1 bit, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, 9 bits, received data, right-aligned, unused MSBs 0.
REQ-011 SHALL have port rx_perr, output, 1 bit, parity error flag of the head frame.
REQ-012 SHALL have port rx_ferr, output, 1 bit, framing error flag of the head frame.
REQ-013 SHALL have port rx_valid, output, 1 bit, FIFO non-empty.
REQ-014 SHALL have port rx_ready, input, 1 bit, consumer accept.
REQ-015 SHALL have port overrun, output, 1 bit, one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port busy, output, 1 bit, high in every FSM state except IDLE.

Function
REQ-017 SHALL synchronise uart_rx through two flops before any use; the synchroniser resets to 1.
REQ-018 SHALL generate a 16x oversample tick every DIV = round(CLK_HZ/(BAUD*16)) clocks from a free-running counter, which restarts at start-edge detection.
REQ-019 SHALL use FSM states IDLE, START, DATA, PAR, STOP: IDLE->START on a synced 1->0 edge; START->DATA after 16 ticks; DATA->PAR (or STOP when PARITY=0) after DATA_BITS bits; PAR->STOP after 1 bit; STOP->IDLE after STOP_BITS bits.
REQ-020 SHALL decide each bit by majority vote of oversample ticks 7, 8 and 9 within the bit.
REQ-021 SHALL return from START to IDLE without a push if the start-bit vote is 1 (false start).
REQ-022 SHALL shift data LSB first.
REQ-023 SHALL set perr when the XOR of the data bits and the parity bit differs from the PARITY setting (odd parity requires XOR = 1).
REQ-024 SHALL set ferr if any stop-bit vote is 0.
REQ-025 SHALL, in STOP, push {perr, ferr, data} into the FIFO at the final stop-bit vote; rx_valid rises on the next clock.
REQ-026 SHALL drive rx_data, rx_perr and rx_ferr from the FIFO head; a pop occurs when rx_valid && rx_ready.
REQ-027 SHALL, on a push while the FIFO is full with no simultaneous pop, drop the new frame, retain the FIFO contents and pulse overrun for 1 clock.
REQ-028 SHALL, when full with push and pop in the same cycle, complete both with no overrun.
REQ-029 SHALL, when empty, hold rx_data, rx_perr and rx_ferr at 0 and ignore rx_ready.
REQ-030 SHALL, after a frame with ferr, wait in IDLE for the line to be high before accepting a new edge (break tolerance).
REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and count occupancy 0..FIFO_DEPTH.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear the FSM to IDLE, all counters, the shift register and the FIFO pointers.
REQ-033 SHALL hold rx_valid=0, busy=0, overrun=0 and rx_data, rx_perr, rx_ferr = 0 while in reset.
REQ-034 SHALL discard a frame that is in progress when reset asserts, with no push after release.

Structure
REQ-035 SHALL place the parity encoding constants (NONE, ODD, EVEN) and the FSM state encoding in the shared package uart_pkg.
REQ-036 SHALL implement the FIFO as sub-module uart_sync_fifo, with parameters WIDTH and DEPTH.

Verification
REQ-037 SHALL cover: defaults, 8N1 frame 0xA5 -> rx_valid, rx_data=0x0A5, perr=0, ferr=0.
REQ-038 SHALL cover: PARITY=2, frame 0x3C with parity bit 1 -> rx_perr=1, rx_data=0x03C.
REQ-039 SHALL cover: stop bit driven 0 on frame 0x55 -> rx_ferr=1, no new edge accepted until the line is high.
REQ-040 SHALL cover: a 4-clock low glitch on an idle line -> no push, busy returns to 0 within one bit time.
REQ-041 SHALL cover: rx_ready=0, five frames 0x01..0x05 -> overrun pulse on the fifth frame, pops yield 0x01..0x04.
REQ-042 SHALL cover: DATA_BITS=7, STOP_BITS=2, frame 0x7F -> rx_data=0x07F, ferr=0; reset mid-frame -> no push.
